// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
// Arbiter FSM state encoding and grant-width helper.
package axis_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  function automatic int arb_grant_bits(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/axis_register.sv
// Full-throughput AXI-Stream register slice with a one-entry skid buffer.
// s_tready depends only on internal state, so no path from m_tready.
module axis_register #(
  parameter int DATA_W = 8,
  parameter int USER_W = 1
) (
  input  logic              clk,
  input  logic              aresetn,
  output logic              s_tready,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              m_tready,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser
);

  localparam int PW = DATA_W + USER_W + 1;

  logic [PW-1:0] s_pay;
  logic [PW-1:0] m_q;
  logic [PW-1:0] skid_q;
  logic          m_v;
  logic          skid_v;

  assign s_pay    = {s_tlast, s_tuser, s_tdata};
  assign s_tready = !skid_v;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_q    <= '0;
      skid_q <= '0;
      m_v    <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (m_tready) begin
        m_q    <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (!m_v || m_tready) begin
      m_v <= s_tvalid;
      if (s_tvalid) m_q <= s_pay;
    end else if (s_tvalid) begin
      // output stalled: park the accepted beat
      skid_q <= s_pay;
      skid_v <= 1'b1;
    end
  end

  assign m_tvalid = m_v;
  assign m_tlast  = m_q[PW-1];
  assign m_tuser  = m_q[PW-2 -: USER_W];
  assign m_tdata  = m_q[DATA_W-1:0];

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-aware round-robin merge of NUM_STREAMS AXI-Stream inputs.
// Define AXIS_ARB_TID_EN to add axis_o_tid carrying the source index.
module axis_packet_arbiter
  import axis_pkg::*;
#(
  parameter  int AXIS_BYTES     = 1,
  parameter  int AXIS_USER_BITS = 1,
  parameter  int NUM_STREAMS    = 2,
  localparam int GRANT_BITS     = arb_grant_bits(NUM_STREAMS)
) (
  input  logic                                  clk,
  input  logic                                  aresetn,
  output logic [NUM_STREAMS-1:0]                axis_i_tready,
  input  logic [NUM_STREAMS-1:0]                axis_i_tvalid,
  input  logic [NUM_STREAMS-1:0]                axis_i_tlast,
  input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                                  axis_o_tready,
  output logic                                  axis_o_tvalid,
  output logic                                  axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]               axis_o_tdata,
`ifdef AXIS_ARB_TID_EN
  output logic [AXIS_USER_BITS-1:0]             axis_o_tuser,
  output logic [GRANT_BITS-1:0]                 axis_o_tid
`else
  output logic [AXIS_USER_BITS-1:0]             axis_o_tuser
`endif
);

  localparam int DW = AXIS_BYTES * 8;
  localparam int UW = AXIS_USER_BITS;
`ifdef AXIS_ARB_TID_EN
  localparam int RUW = UW + GRANT_BITS;
`else
  localparam int RUW = UW;
`endif

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [GRANT_BITS-1:0] grant;
  logic [GRANT_BITS-1:0] grant_nxt;
  logic [GRANT_BITS-1:0] rr_ptr;
  logic [GRANT_BITS-1:0] rr_nxt;

  logic                  found;
  logic [GRANT_BITS-1:0] pick;
  logic [GRANT_BITS-1:0] idx;
  logic [GRANT_BITS:0]   sum;

  logic                  busy;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DW-1:0]         sel_data;
  logic [UW-1:0]         sel_user;
  logic [RUW-1:0]        reg_user_in;
  logic [RUW-1:0]        reg_user_out;
  logic                  reg_ready;
  logic                  s_valid;
  logic                  accept;

  // first valid stream after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    sum   = '0;
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      sum = {1'b0, rr_ptr} + (GRANT_BITS+1)'(k);
      if (sum >= (GRANT_BITS+1)'(NUM_STREAMS))
        sum = sum - (GRANT_BITS+1)'(NUM_STREAMS);
      idx = sum[GRANT_BITS-1:0];
      if (!found && axis_i_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign busy      = (state == ARB_BUSY);
  assign sel_valid = axis_i_tvalid[grant];
  assign sel_last  = axis_i_tlast[grant];
  assign sel_data  = axis_i_tdata[int'(grant)*DW +: DW];
  assign sel_user  = axis_i_tuser[int'(grant)*UW +: UW];
  assign s_valid   = busy && sel_valid;
  assign accept    = s_valid && reg_ready;

  always_comb begin
    axis_i_tready = '0;
    if (busy) axis_i_tready[grant] = reg_ready;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= GRANT_BITS'(NUM_STREAMS - 1);
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    unique case (state)
      ARB_IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (accept && sel_last) begin
          rr_nxt    = grant;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

`ifdef AXIS_ARB_TID_EN
  assign reg_user_in = {grant, sel_user};
  assign axis_o_tid  = reg_user_out[RUW-1 -: GRANT_BITS];
`else
  assign reg_user_in = sel_user;
`endif
  assign axis_o_tuser = reg_user_out[UW-1:0];

  axis_register #(
    .DATA_W (DW),
    .USER_W (RUW)
  ) u_out_reg (
    .clk      (clk),
    .aresetn  (aresetn),
    .s_tready (reg_ready),
    .s_tvalid (s_valid),
    .s_tlast  (sel_last),
    .s_tdata  (sel_data),
    .s_tuser  (reg_user_in),
    .m_tready (axis_o_tready),
    .m_tvalid (axis_o_tvalid),
    .m_tlast  (axis_o_tlast),
    .m_tdata  (axis_o_tdata),
    .m_tuser  (reg_user_out)
  );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter (3 streams).
// Packet-level reference: per-stream queues plus round-robin pick.
module tb_axis_packet_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int UW = 2;
  localparam int GB = 2;

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    tready;
  logic [N-1:0]    tvalid = '0;
  logic [N-1:0]    tlast = '0;
  logic [N*DW-1:0] tdata = '0;
  logic [N*UW-1:0] tuser = '0;
  logic            o_tready = 1'b0;
  logic            o_tvalid;
  logic            o_tlast;
  logic [DW-1:0]   o_tdata;
  logic [UW-1:0]   o_tuser;
`ifdef AXIS_ARB_TID_EN
  logic [GB-1:0]   o_tid;
`endif

  always #5 clk = ~clk;

  axis_packet_arbiter #(
    .AXIS_BYTES     (1),
    .AXIS_USER_BITS (UW),
    .NUM_STREAMS    (N)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .axis_i_tready (tready),
    .axis_i_tvalid (tvalid),
    .axis_i_tlast  (tlast),
    .axis_i_tdata  (tdata),
    .axis_i_tuser  (tuser),
    .axis_o_tready (o_tready),
    .axis_o_tvalid (o_tvalid),
    .axis_o_tlast  (o_tlast),
    .axis_o_tdata  (o_tdata),
`ifdef AXIS_ARB_TID_EN
    .axis_o_tuser  (o_tuser),
    .axis_o_tid    (o_tid)
`else
    .axis_o_tuser  (o_tuser)
`endif
  );

  beat_t drv_q[N][$];
  beat_t exp_q[N][$];
  bit    in_pkt[N];
  int    stall[N];
  int    stall_pct = 0;
  int    force_stall0 = 0;
  int    ordy_mode = 0;
  int    model_rr = N - 1;
  int    cur_src = -1;
  int    cycle = 0;
  int    last_fire = -1;
  bit    gap_chk = 0;
  bit    prev_hold = 0;
  beat_t prev_out;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int t;
    t = 0;
    for (int s = 0; s < N; s++) t += exp_q[s].size();
    return t;
  endfunction

  task automatic push_beat(input int s, input beat_t b);
    drv_q[s].push_back(b);
    exp_q[s].push_back(b);
  endtask

  task automatic load(input int s, input int npk,
                      input int lmin, input int lmax);
    beat_t b;
    int    len;
    for (int p = 0; p < npk; p++) begin
      len = $urandom_range(lmin, lmax);
      for (int i = 0; i < len; i++) begin
        b.data = DW'($urandom);
        b.user = UW'($urandom);
        b.last = (i == len - 1);
        push_beat(s, b);
      end
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int s = 0; s < N; s++) begin
      if (drv_q[s].size() > 0) begin
        b = drv_q[s][0];
        tvalid[s] = (stall[s] == 0);
        tlast[s]  = b.last;
        tdata[s*DW +: DW] = b.data;
        tuser[s*UW +: UW] = b.user;
      end else begin
        tvalid[s] = 1'b0;
        tlast[s]  = 1'b0;
        tdata[s*DW +: DW] = '0;
        tuser[s*UW +: UW] = '0;
      end
    end
    case (ordy_mode)
      1:       o_tready = (cycle % 2 == 0);
      2:       o_tready = ($urandom_range(0, 3) != 0);
      default: o_tready = 1'b1;
    endcase
  endtask

  task automatic score();
    beat_t e;
    if (cur_src < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (cur_src < 0 && exp_q[(model_rr + k) % N].size() > 0)
          cur_src = (model_rr + k) % N;
      end
    end
    if (cur_src < 0) begin
      chk("spurious_beat", 32'(o_tvalid), 32'd0);
      return;
    end
    e = exp_q[cur_src].pop_front();
    chk("out_beat", 32'({o_tlast, o_tuser, o_tdata}), 32'(e));
`ifdef AXIS_ARB_TID_EN
    chk("out_tid", 32'(o_tid), 32'(cur_src));
`endif
    if (gap_chk && last_fire >= 0)
      chk("beat_gap", 32'(cycle - last_fire), 32'd2);
    last_fire = cycle;
    if (e.last) begin
      model_rr = cur_src;
      cur_src  = -1;
    end
  endtask

  task automatic tick();
    bit    fire[N];
    beat_t b;
    @(negedge clk);
    drive();
    #4;
    chk("tready_onehot0", 32'($onehot0(tready)), 32'd1);
    for (int s = 0; s < N; s++) begin
      if (in_pkt[s])
        chk("nongrant_tready", 32'(tready & ~(N'(1) << s)), 32'd0);
    end
    if (prev_hold) begin
      chk("hold_valid", 32'(o_tvalid), 32'd1);
      chk("hold_beat", 32'({o_tlast, o_tuser, o_tdata}), 32'(prev_out));
    end
    if (o_tvalid && o_tready) score();
    prev_hold = o_tvalid && !o_tready;
    prev_out  = {o_tlast, o_tuser, o_tdata};
    for (int s = 0; s < N; s++) fire[s] = tvalid[s] && tready[s];
    @(posedge clk);
    #1;
    cycle++;
    for (int s = 0; s < N; s++) begin
      if (fire[s]) begin
        b = drv_q[s].pop_front();
        in_pkt[s] = !b.last;
        if (in_pkt[s] && s == 0 && force_stall0 > 0) begin
          stall[s] = force_stall0;
          force_stall0 = 0;
        end else if (in_pkt[s] && $urandom_range(0, 99) < stall_pct) begin
          stall[s] = $urandom_range(1, 4);
        end
      end else if (stall[s] > 0) begin
        stall[s]--;
      end
    end
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain", 32'(pending()), 32'd0);
    for (int s = 0; s < N; s++) begin
      drv_q[s].delete();
      exp_q[s].delete();
    end
    repeat (2) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tready", 32'(tready), 32'd0);
    for (int s = 0; s < N; s++) begin
      drv_q[s].delete();
      exp_q[s].delete();
      in_pkt[s] = 1'b0;
      stall[s]  = 0;
    end
    tvalid    = '0;
    model_rr  = N - 1;
    cur_src   = -1;
    prev_hold = 1'b0;
    last_fire = -1;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    beat_t b;
    int    n;
    for (int s = 0; s < N; s++) begin
      in_pkt[s] = 1'b0;
      stall[s]  = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_o_tvalid", 32'(o_tvalid), 32'd0);
    chk("reset_o_tlast", 32'(o_tlast), 32'd0);
    chk("reset_o_tdata", 32'(o_tdata), 32'd0);
    chk("reset_o_tuser", 32'(o_tuser), 32'd0);
    chk("reset_tready", 32'(tready), 32'd0);
`ifdef AXIS_ARB_TID_EN
    chk("reset_o_tid", 32'(o_tid), 32'd0);
`endif
    aresetn = 1'b1;

    // single 3-beat packet on s0
    for (int i = 0; i < 3; i++) begin
      b.data = DW'(8'hA0 + i);
      b.user = '0;
      b.last = (i == 2);
      push_beat(0, b);
    end
    run(40);

    // all streams saturated with 2-beat packets
    do_reset();
    for (int s = 0; s < N; s++) load(s, 4, 2, 2);
    run(200);

    // s0 stalls 4 cycles mid-packet while s1 waits
    do_reset();
    load(0, 1, 4, 4);
    load(1, 1, 2, 2);
    force_stall0 = 4;
    run(60);

    // toggling output ready
    do_reset();
    ordy_mode = 1;
    load(0, 1, 4, 4);
    load(2, 1, 3, 3);
    run(60);
    ordy_mode = 0;

    // reset during beat 2 of 4, then s0 keeps priority
    do_reset();
    load(0, 1, 4, 4);
    load(1, 1, 2, 2);
    n = 0;
    while (drv_q[0].size() > 2 && n < 40) begin
      tick();
      n++;
    end
    chk("mid_pkt_progress", 32'(drv_q[0].size()), 32'd2);
    do_reset();
    load(1, 1, 2, 3);
    load(0, 1, 2, 3);
    run(60);

    // back-to-back single-beat packets on s1
    do_reset();
    load(1, 6, 1, 1);
    gap_chk = 1'b1;
    run(60);
    gap_chk = 1'b0;

    // randomized traffic, stalls and backpressure
    do_reset();
    stall_pct = 30;
    ordy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 3) != 0) load(s, $urandom_range(1, 5), 1, 5);
      run(2000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
